// File: rtl/player_dir_input_ctrl.sv
// Per-player direction input front end: sync, debounce, heading resolve, round-robin event queue.
// Optional PS2_DIR_EN adds a keyboard scan-code path that sets headings directly.
module player_dir_input_ctrl #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int PID_W           = 3
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [4*NUM_PLAYERS-1:0]   dir_raw,
    output logic [2*NUM_PLAYERS-1:0]   dir_held,
    output logic [NUM_PLAYERS-1:0]     dir_known,
    output logic                       evt_valid,
    output logic [PID_W-1:0]           evt_player,
    output logic [1:0]                 evt_dir,
    input  logic                       evt_ack
`ifdef PS2_DIR_EN
    ,
    input  logic                       ps2_key_pressed,
    input  logic [7:0]                 ps2_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4*NUM_PLAYERS-1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_PLAYERS-1:0][3:0]          cand_q, cand_d, stable_q, stable_d;
    logic [NUM_PLAYERS-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_PLAYERS-1:0]               chg_q, chg_d;
    logic [NUM_PLAYERS-1:0][1:0]          held_q, held_d;
    logic [NUM_PLAYERS-1:0]               known_q, known_d;
    logic [NUM_PLAYERS-1:0]               pending_q, pending_d;
    logic [PID_W-1:0]                     rr_q, rr_d;
    logic                                 evt_valid_q, evt_valid_d;
    logic [PID_W-1:0]                     evt_player_q, evt_player_d;
    logic [1:0]                           evt_dir_q, evt_dir_d;

    logic [NUM_PLAYERS-1:0]               res_vld, set_mask;
    logic [NUM_PLAYERS-1:0][1:0]          res_hdg;
    logic [NUM_PLAYERS-1:0]               ps2_vld;
    logic [NUM_PLAYERS-1:0][1:0]          ps2_hdg;
    logic                                 found;
    int                                   sel, idx;
    logic [1:0]                           sel_dir;

    always_comb begin
        sync1_d = dir_raw;
        sync2_d = sync1_q;
    end

    // chg_d flags a real change of the debounced vector so the resolver acts once per change
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        chg_d    = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (sync2_q[4*p +: 4] != cand_q[p]) begin
                cand_d[p] = sync2_q[4*p +: 4];
                cnt_d[p]  = '0;
            end else if (cnt_q[p] == CNT_LAST) begin
                stable_d[p] = cand_q[p];
                chg_d[p]    = (cand_q[p] != stable_q[p]);
            end else begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end
        end
    end

`ifdef PS2_DIR_EN
    localparam int P1 = (NUM_PLAYERS >= 2) ? 1 : 0;
    logic brk_q, brk_d;

    // 0xE0 prefixes are skipped outright; 0xF0 swallows the next code byte
    always_comb begin
        brk_d   = brk_q;
        ps2_vld = '0;
        ps2_hdg = '0;
        if (ps2_key_pressed) begin
            if (ps2_out == 8'hF0) begin
                brk_d = 1'b1;
            end else if (ps2_out != 8'hE0) begin
                brk_d = 1'b0;
                if (!brk_q) begin
                    case (ps2_out)
                        8'h1D: begin ps2_vld[0] = 1'b1; ps2_hdg[0] = 2'd0; end
                        8'h23: begin ps2_vld[0] = 1'b1; ps2_hdg[0] = 2'd1; end
                        8'h1B: begin ps2_vld[0] = 1'b1; ps2_hdg[0] = 2'd2; end
                        8'h1C: begin ps2_vld[0] = 1'b1; ps2_hdg[0] = 2'd3; end
                        8'h75: if (NUM_PLAYERS >= 2) begin ps2_vld[P1] = 1'b1; ps2_hdg[P1] = 2'd0; end
                        8'h74: if (NUM_PLAYERS >= 2) begin ps2_vld[P1] = 1'b1; ps2_hdg[P1] = 2'd1; end
                        8'h72: if (NUM_PLAYERS >= 2) begin ps2_vld[P1] = 1'b1; ps2_hdg[P1] = 2'd2; end
                        8'h6B: if (NUM_PLAYERS >= 2) begin ps2_vld[P1] = 1'b1; ps2_hdg[P1] = 2'd3; end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) brk_q <= 1'b0;
        else         brk_q <= brk_d;
    end
`else
    assign ps2_vld = '0;
    assign ps2_hdg = '0;
`endif

    // Zero or multiple bits keep the previous heading; a keyboard hit overrides the switch path
    always_comb begin
        res_vld = '0;
        res_hdg = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (chg_q[p]) begin
                case (stable_q[p])
                    4'b0001: begin res_vld[p] = 1'b1; res_hdg[p] = 2'd0; end
                    4'b0010: begin res_vld[p] = 1'b1; res_hdg[p] = 2'd1; end
                    4'b0100: begin res_vld[p] = 1'b1; res_hdg[p] = 2'd2; end
                    4'b1000: begin res_vld[p] = 1'b1; res_hdg[p] = 2'd3; end
                    default: ;
                endcase
            end
            if (ps2_vld[p]) begin
                res_vld[p] = 1'b1;
                res_hdg[p] = ps2_hdg[p];
            end
        end
    end

    always_comb begin
        held_d   = held_q;
        known_d  = known_q;
        set_mask = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (res_vld[p] && (res_hdg[p] != held_q[p] || !known_q[p])) begin
                held_d[p]   = res_hdg[p];
                known_d[p]  = 1'b1;
                set_mask[p] = 1'b1;
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        sel     = 0;
        idx     = 0;
        sel_dir = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_PLAYERS) idx = idx - NUM_PLAYERS;
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (!found && j == idx && pending_q[j]) begin
                    found = 1'b1;
                    sel   = j;
                end
            end
        end
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (j == sel) sel_dir = held_q[j];
        end
    end

    // Pending survives an ack when the heading moved on after the event was loaded
    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_player_d = evt_player_q;
        evt_dir_d    = evt_dir_q;
        rr_d         = rr_q;
        pending_d    = pending_q;
        if (evt_valid_q) begin
            if (evt_ack) begin
                evt_valid_d = 1'b0;
                rr_d = (evt_player_q == PID_W'(NUM_PLAYERS - 1)) ? '0 : evt_player_q + PID_W'(1);
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (PID_W'(p) == evt_player_q && held_q[p] == evt_dir_q) pending_d[p] = 1'b0;
                end
            end
        end else if (found) begin
            evt_valid_d  = 1'b1;
            evt_player_d = PID_W'(sel);
            evt_dir_d    = sel_dir;
        end
        pending_d = pending_d | set_mask;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            cand_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= '0;
            chg_q        <= '0;
            held_q       <= '0;
            known_q      <= '0;
            pending_q    <= '0;
            rr_q         <= '0;
            evt_valid_q  <= 1'b0;
            evt_player_q <= '0;
            evt_dir_q    <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            chg_q        <= chg_d;
            held_q       <= held_d;
            known_q      <= known_d;
            pending_q    <= pending_d;
            rr_q         <= rr_d;
            evt_valid_q  <= evt_valid_d;
            evt_player_q <= evt_player_d;
            evt_dir_q    <= evt_dir_d;
        end
    end

    assign dir_held   = held_q;
    assign dir_known  = known_q;
    assign evt_valid  = evt_valid_q;
    assign evt_player = evt_player_q;
    assign evt_dir    = evt_dir_q;

endmodule

// File: tb/tb_player_dir_input_ctrl.sv
// Directed bench for player_dir_input_ctrl with two players and an 8-clock debounce window.
module tb_player_dir_input_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] dir_raw;
    logic [3:0] dir_held;
    logic [1:0] dir_known;
    logic       evt_valid;
    logic [2:0] evt_player;
    logic [1:0] evt_dir;
    logic       evt_ack;
`ifdef PS2_DIR_EN
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    player_dir_input_ctrl #(
        .NUM_PLAYERS(2), .DEBOUNCE_CYCLES(8), .CNT_W(4), .PID_W(3)
    ) dut (
        .clock(clock), .resetn(resetn), .dir_raw(dir_raw),
        .dir_held(dir_held), .dir_known(dir_known),
        .evt_valid(evt_valid), .evt_player(evt_player), .evt_dir(evt_dir),
        .evt_ack(evt_ack)
`ifdef PS2_DIR_EN
        , .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_evt(input string tag, input logic v, input logic [2:0] pl, input logic [1:0] d);
        chk({tag, "_valid"}, 32'(evt_valid), 32'(v));
        if (v) begin
            chk({tag, "_player"}, 32'(evt_player), 32'(pl));
            chk({tag, "_dir"}, 32'(evt_dir), 32'(d));
        end
    endtask

`ifdef PS2_DIR_EN
    task automatic ps2_send(input logic [7:0] b);
        ps2_key_pressed = 1'b1;
        ps2_out         = b;
        wait_n(1);
        ps2_key_pressed = 1'b0;
        ps2_out         = 8'h00;
    endtask
`endif

    initial begin
        resetn  = 1'b0;
        dir_raw = 8'h00;
        evt_ack = 1'b0;
`ifdef PS2_DIR_EN
        ps2_key_pressed = 1'b0;
        ps2_out         = 8'h00;
`endif
        wait_n(3);
        chk("rst_held", 32'(dir_held), 0);
        chk("rst_known", 32'(dir_known), 0);
        chk_evt("rst_evt", 1'b0, 3'd0, 2'd0);
        chk("rst_player", 32'(evt_player), 0);
        chk("rst_dir", 32'(evt_dir), 0);
        resetn = 1'b1;
        wait_n(20);
        chk("idle_known", 32'(dir_known), 0);
        chk("idle_valid", 32'(evt_valid), 0);

        // P0 up: valid appears on the 13th edge after the change
        dir_raw = 8'b0000_0001;
        wait_n(12);
        chk("up_early_valid", 32'(evt_valid), 0);
        chk("up_known", 32'(dir_known), 1);
        wait_n(1);
        chk_evt("up_evt", 1'b1, 3'd0, 2'd0);
        evt_ack = 1'b1;
        wait_n(1);
        evt_ack = 1'b0;
        chk("up_acked", 32'(evt_valid), 0);
        wait_n(2);
        chk("up_no_repeat", 32'(evt_valid), 0);

        // Short glitch, then a two-bit vector long enough to settle
        dir_raw = 8'b0000_0011;
        wait_n(5);
        dir_raw = 8'b0000_0001;
        wait_n(20);
        chk("glitch_valid", 32'(evt_valid), 0);
        chk("glitch_held", 32'(dir_held), 0);
        dir_raw = 8'b0000_0011;
        wait_n(20);
        chk("twobit_valid", 32'(evt_valid), 0);
        chk("twobit_held", 32'(dir_held), 0);
        dir_raw = 8'b0000_0001;
        wait_n(15);
        chk("repress_valid", 32'(evt_valid), 0);

        // Reset clears rr pointer and knowledge
        resetn  = 1'b0;
        dir_raw = 8'h00;
        wait_n(3);
        chk("rst2_known", 32'(dir_known), 0);
        resetn = 1'b1;
        wait_n(3);

        // Simultaneous change, ack held high
        dir_raw = 8'b0010_0100;
        evt_ack = 1'b1;
        wait_n(12);
        chk("sim_early_valid", 32'(evt_valid), 0);
        chk("sim_held", 32'(dir_held), 32'h6);
        chk("sim_known", 32'(dir_known), 3);
        wait_n(1);
        chk_evt("sim_e0", 1'b1, 3'd0, 2'd2);
        wait_n(1);
        chk("sim_gap", 32'(evt_valid), 0);
        wait_n(1);
        chk_evt("sim_e1", 1'b1, 3'd1, 2'd1);
        wait_n(1);
        chk("sim_done", 32'(evt_valid), 0);
        wait_n(2);
        chk("ack_no_valid", 32'(evt_valid), 0);

        // P0 alone moves rr to 1, then both change: P1 served first
        dir_raw = 8'b0010_1000;
        wait_n(13);
        chk_evt("r2_e0", 1'b1, 3'd0, 2'd3);
        wait_n(1);
        chk("r2_done", 32'(evt_valid), 0);
        wait_n(2);
        dir_raw = 8'b0100_0001;
        wait_n(13);
        chk_evt("r3_e1", 1'b1, 3'd1, 2'd2);
        wait_n(1);
        chk("r3_gap", 32'(evt_valid), 0);
        wait_n(1);
        chk_evt("r3_e0", 1'b1, 3'd0, 2'd0);
        wait_n(1);
        chk("r3_done", 32'(evt_valid), 0);
        chk("r3_held", 32'(dir_held), 32'h8);

        // Coalescing: P1 right, then down while unacknowledged
        evt_ack = 1'b0;
        dir_raw = 8'b0010_0001;
        wait_n(12);
        chk("co_held1", 32'(dir_held), 32'h4);
        wait_n(1);
        chk_evt("co_e_right", 1'b1, 3'd1, 2'd1);
        dir_raw = 8'b0100_0001;
        wait_n(12);
        chk("co_held2", 32'(dir_held), 32'h8);
        chk_evt("co_stable", 1'b1, 3'd1, 2'd1);
        evt_ack = 1'b1;
        wait_n(1);
        evt_ack = 1'b0;
        chk("co_ack1", 32'(evt_valid), 0);
        wait_n(1);
        chk_evt("co_e_down", 1'b1, 3'd1, 2'd2);
        evt_ack = 1'b1;
        wait_n(1);
        evt_ack = 1'b0;
        chk("co_ack2", 32'(evt_valid), 0);
        wait_n(3);
        chk("co_drained", 32'(evt_valid), 0);

`ifdef PS2_DIR_EN
        ps2_send(8'h1C);
        chk("ps2_left_held", 32'(dir_held), 32'hB);
        wait_n(1);
        chk_evt("ps2_left_evt", 1'b1, 3'd0, 2'd3);
        evt_ack = 1'b1;
        wait_n(1);
        evt_ack = 1'b0;
        ps2_send(8'h1D);
        chk("ps2_up_held", 32'(dir_held), 32'h8);
        wait_n(1);
        chk_evt("ps2_up_evt", 1'b1, 3'd0, 2'd0);
        evt_ack = 1'b1;
        wait_n(1);
        evt_ack = 1'b0;
        ps2_send(8'hF0);
        ps2_send(8'h1C);
        chk("ps2_brk_held", 32'(dir_held), 32'h8);
        wait_n(3);
        chk("ps2_brk_valid", 32'(evt_valid), 0);
`endif

        // Async reset while an event is presented
        dir_raw = 8'b0100_0010;
        wait_n(13);
        chk_evt("mid_evt", 1'b1, 3'd0, 2'd1);
        chk("mid_held", 32'(dir_held), 32'h9);
        #2 resetn = 1'b0;
        #1;
        chk("arst_held", 32'(dir_held), 0);
        chk("arst_known", 32'(dir_known), 0);
        chk("arst_valid", 32'(evt_valid), 0);
        chk("arst_player", 32'(evt_player), 0);
        chk("arst_dir", 32'(evt_dir), 0);
        wait_n(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
